// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM state encoding,
// legal oversample range and word-length decoding.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PAR    = 3'd3,
    STOP   = 3'd4,
    RESYNC = 3'd5
  } uart_state_e;

  localparam int unsigned OVERSAMPLE_MIN = 4;
  localparam int unsigned OVERSAMPLE_MAX = 32;

  // 2'b00..2'b11 selects 5..8 data bits.
  function automatic logic [3:0] word_bits(input logic [1:0] word_len);
    return 4'd5 + {2'b00, word_len};
  endfunction

endpackage

// File: rtl/uart_rx_engine_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_rx_engine_sync #(
  parameter int unsigned NrStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [NrStages-1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= '1;
    end else begin
      ff_q <= (ff_q << 1) | NrStages'(d_i);
    end
  end

  assign q_o = ff_q[NrStages-1];

endmodule

// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver: majority-voted sampling, 5..8 data bits,
// optional (stick) parity, break/framing detection and a held output register.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int unsigned OversampleRate = 16,
  parameter int unsigned NrSyncStages   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        baud_tick_i,
  input  logic        rx_i,
  input  logic [1:0]  word_len_i,
  input  logic        par_en_i,
  input  logic        even_par_i,
  input  logic        force_par_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        par_err_o,
  output logic        frame_err_o,
  output logic        break_o,
  output logic        overrun_o,
  output logic        busy_o,
  output uart_state_e state_o
);

  // Output handshake: a character is transferred on any rising clk_i edge
  // where valid_o && ready_i; data_o and the flags stay stable while valid_o
  // is high and not yet accepted.

  localparam int unsigned CntW = $clog2(OversampleRate);
  localparam logic [CntW-1:0] FullCnt = CntW'(OversampleRate - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(OversampleRate / 2 - 1);

  logic rx_sync;
  logic [1:0] win_q;
  logic vote;

  uart_rx_engine_sync #(.NrStages(NrSyncStages)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (rx_sync)
  );

  // The vote includes the sample arriving on the current tick.
  assign vote = (win_q[1] & win_q[0]) | (win_q[1] & rx_sync) | (win_q[0] & rx_sync);

  uart_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] nbits_q, nbits_d;
  logic par_en_q, par_en_d, even_q, even_d, force_q, force_d;
  logic par_err_q, par_err_d, par_bit_q, par_bit_d;
  logic ferr_q, ferr_d, brk_q, brk_d;
  logic done_q, done_d;
  logic exp_par;

  assign exp_par = force_q ? ~even_q : ((^shreg_q) ^ ~even_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      win_q     <= 2'b11;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      nbits_q   <= 4'd8;
      par_en_q  <= 1'b0;
      even_q    <= 1'b0;
      force_q   <= 1'b0;
      par_err_q <= 1'b0;
      par_bit_q <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (baud_tick_i) win_q <= {win_q[0], rx_sync};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      even_q    <= even_d;
      force_q   <= force_d;
      par_err_q <= par_err_d;
      par_bit_q <= par_bit_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    even_d    = even_q;
    force_d   = force_q;
    par_err_d = par_err_q;
    par_bit_d = par_bit_q;
    ferr_d    = ferr_q;
    brk_d     = brk_q;
    done_d    = 1'b0;
    if (baud_tick_i) begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!rx_sync) state_d = START;
        end
        START: begin
          if (cnt_q == HalfCnt) begin
            cnt_d = '0;
            if (vote) begin
              state_d = IDLE;
            end else begin
              // Frame confirmed: freeze the configuration for this character.
              state_d   = DATA;
              bit_d     = '0;
              shreg_d   = '0;
              nbits_d   = word_bits(word_len_i);
              par_en_d  = par_en_i;
              even_d    = even_par_i;
              force_d   = force_par_i;
              par_err_d = 1'b0;
              par_bit_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        DATA: begin
          if (cnt_q == FullCnt) begin
            cnt_d          = '0;
            shreg_d[bit_q] = vote;
            bit_d          = bit_q + 3'd1;
            if ({1'b0, bit_q} + 4'd1 == nbits_q) state_d = par_en_q ? PAR : STOP;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        PAR: begin
          if (cnt_q == FullCnt) begin
            cnt_d     = '0;
            par_bit_d = vote;
            par_err_d = (vote != exp_par);
            state_d   = STOP;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        STOP: begin
          if (cnt_q == FullCnt) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            ferr_d  = ~vote;
            brk_d   = ~vote && (shreg_q == 8'h00) && (!par_en_q || !par_bit_q);
            state_d = vote ? IDLE : RESYNC;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        RESYNC: begin
          if (vote) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic [7:0] data_q;
  logic valid_q, out_perr_q, out_ferr_q, out_brk_q, overrun_q;
  logic load;

  // Load wins over an acceptance in the same cycle.
  assign load = done_q && (!valid_q || ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      out_perr_q <= 1'b0;
      out_ferr_q <= 1'b0;
      out_brk_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= done_q && valid_q && !ready_i;
      if (load) begin
        data_q     <= shreg_q;
        valid_q    <= 1'b1;
        out_perr_q <= par_err_q;
        out_ferr_q <= ferr_q;
        out_brk_q  <= brk_q;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign par_err_o   = out_perr_q;
  assign frame_err_o = out_ferr_q;
  assign break_o     = out_brk_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: directed scenarios plus randomized
// frames scored against a frame-level reference model.
module tb_uart_rx_engine;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic baud_tick_i = 1'b0;
  logic rx_i = 1'b1;
  logic [1:0] word_len_i = 2'b11;
  logic par_en_i = 1'b0, even_par_i = 1'b0, force_par_i = 1'b0;
  logic ready_i = 1'b0;
  logic [7:0] data_o;
  logic valid_o, par_err_o, frame_err_o, break_o, overrun_o, busy_o;
  uart_state_e state_o;

  int n_checks = 0;
  int n_fail = 0;
  int tick_div = 1;
  int tick_cnt = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int deliveries = 0;
  int ovr_cnt = 0;
  logic valid_prev = 1'b0;

  // {break, frame_err, par_err, data}
  logic [10:0] exp_q[$];

  uart_rx_engine #(.OversampleRate(16), .NrSyncStages(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .baud_tick_i (baud_tick_i),
    .rx_i        (rx_i),
    .word_len_i  (word_len_i),
    .par_en_i    (par_en_i),
    .even_par_i  (even_par_i),
    .force_par_i (force_par_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .par_err_o   (par_err_o),
    .frame_err_o (frame_err_o),
    .break_o     (break_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o),
    .state_o     (state_o)
  );

  // Clock / tick generation and output monitor.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt = 0;
      baud_tick_i = 1'b1;
    end else begin
      tick_cnt++;
      baud_tick_i = 1'b0;
    end
    if (valid_o && !valid_prev) begin
      deliveries++;
      rise_cyc = cyc;
    end
    valid_prev = valid_o;
    if (overrun_o) ovr_cnt++;
  end

  // Reference model: expected character and flags from the transmitted frame.
  function automatic logic [10:0] model_char(logic [7:0] d, int nbits, bit pen, bit even,
                                             bit force_p, bit pbit, bit stop);
    logic [7:0] dm;
    int ones;
    bit want, perr, ferr, brk;
    dm = d & (8'hFF >> (8 - nbits));
    ones = $countones(dm);
    if (force_p) want = !even;
    else if (even) want = (ones % 2 == 1);
    else want = (ones % 2 == 0);
    perr = pen && (pbit != want);
    ferr = !stop;
    brk = !stop && (dm == 8'h00) && (!pen || !pbit);
    return {brk, ferr, perr, dm};
  endfunction

  task automatic bit_wait();
    repeat (16 * tick_div) @(negedge clk);
  endtask

  task automatic set_cfg(int nbits, bit pen, bit even, bit force_p);
    word_len_i = 2'(nbits - 5);
    par_en_i = pen;
    even_par_i = even;
    force_par_i = force_p;
  endtask

  task automatic send_frame(logic [7:0] d, int nbits, bit pen, bit pbit, bit stop, bit scramble);
    rx_i = 1'b0;
    start_cyc = cyc;
    bit_wait();
    if (scramble) begin
      word_len_i = 2'($urandom_range(0, 3));
      par_en_i = 1'($urandom_range(0, 1));
      even_par_i = 1'($urandom_range(0, 1));
      force_par_i = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < nbits; i++) begin
      rx_i = d[i];
      bit_wait();
    end
    if (pen) begin
      rx_i = pbit;
      bit_wait();
    end
    rx_i = stop;
    bit_wait();
    rx_i = 1'b1;
    bit_wait();
    bit_wait();
  endtask

  task automatic wait_valid(string name, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: valid_o not seen within %0d cycles", name, budget);
    end
  endtask

  // Compare the held character with the scoreboard head, then accept it.
  task automatic check_char(string name);
    bit ok;
    logic [10:0] e;
    wait_valid(name, 600, ok);
    if (ok) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: character delivered with empty expected queue, got %02h", name, data_o);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (data_o !== e[7:0]) begin
          n_fail++;
          $display("FAIL %s data: got %02h expected %02h", name, data_o, e[7:0]);
        end
        n_checks++;
        if ({break_o, frame_err_o, par_err_o} !== e[10:8]) begin
          n_fail++;
          $display("FAIL %s flags(brk,ferr,perr): got %b expected %b", name,
                   {break_o, frame_err_o, par_err_o}, e[10:8]);
        end
      end
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
      n_checks++;
      if (valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s accept: valid_o got %b expected 0", name, valid_o);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({valid_o, busy_o, par_err_o, frame_err_o, break_o, overrun_o} !== 6'b0 || data_o !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid/busy/flags %b data %02h expected 0", 
               {valid_o, busy_o, par_err_o, frame_err_o, break_o, overrun_o}, data_o);
    end
    rst_ni = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (state_o !== IDLE || busy_o !== 1'b0 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: state %0d busy %b valid %b expected IDLE/0/0", state_o, busy_o, valid_o);
    end
  endtask

  task automatic test_8n1();
    int d0;
    set_cfg(8, 0, 0, 0);
    d0 = deliveries;
    exp_q.push_back(model_char(8'hA5, 8, 0, 0, 0, 0, 1));
    send_frame(8'hA5, 8, 0, 0, 1, 0);
    // 2 sync stages + 1 detect tick + half bit + 8 data + stop bit + load clock
    n_checks++;
    if (deliveries - d0 != 1 || rise_cyc - start_cyc != 2 + 1 + 8 + 9 * 16 + 1) begin
      n_fail++;
      $display("FAIL 8n1_latency: deliveries %0d latency %0d expected 1 and %0d",
               deliveries - d0, rise_cyc - start_cyc, 2 + 1 + 8 + 9 * 16 + 1);
    end
    check_char("8n1_a5");
  endtask

  task automatic test_parity();
    set_cfg(7, 1, 1, 0);
    exp_q.push_back(model_char(8'h41, 7, 1, 1, 0, 1, 1));
    send_frame(8'h41, 7, 1, 1, 1, 0);
    check_char("7e1_bad_par");
    exp_q.push_back(model_char(8'h41, 7, 1, 1, 0, 0, 1));
    send_frame(8'h41, 7, 1, 0, 1, 0);
    check_char("7e1_good_par");
    set_cfg(8, 1, 0, 1);
    exp_q.push_back(model_char(8'h3C, 8, 1, 0, 1, 0, 1));
    send_frame(8'h3C, 8, 1, 0, 1, 0);
    check_char("stick_par");
  endtask

  task automatic test_glitch();
    int d0;
    d0 = deliveries;
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy: busy_o got %b expected 1", busy_o);
    end
    repeat (200) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || state_o !== IDLE || deliveries != d0 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_idle: busy %b state %0d new chars %0d valid %b expected 0/IDLE/0/0",
               busy_o, state_o, deliveries - d0, valid_o);
    end
  endtask

  task automatic test_break();
    int d0;
    set_cfg(8, 0, 0, 0);
    d0 = deliveries;
    exp_q.push_back(model_char(8'h00, 8, 0, 0, 0, 0, 0));
    rx_i = 1'b0;
    repeat (320) @(negedge clk);
    n_checks++;
    if (deliveries - d0 != 1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL break_hold: chars %0d busy %b expected 1 and 1", deliveries - d0, busy_o);
    end
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || deliveries - d0 != 1) begin
      n_fail++;
      $display("FAIL break_resync: busy %b chars %0d expected 0 and 1", busy_o, deliveries - d0);
    end
    check_char("break");
    exp_q.push_back(model_char(8'h96, 8, 0, 0, 0, 0, 1));
    send_frame(8'h96, 8, 0, 0, 1, 0);
    check_char("after_break");
  endtask

  task automatic test_overrun();
    int d0, o0;
    set_cfg(8, 0, 0, 0);
    d0 = deliveries;
    o0 = ovr_cnt;
    exp_q.push_back(model_char(8'h11, 8, 0, 0, 0, 0, 1));
    send_frame(8'h11, 8, 0, 0, 1, 0);
    send_frame(8'h22, 8, 0, 0, 1, 0);
    n_checks++;
    if (ovr_cnt - o0 != 1 || deliveries - d0 != 1) begin
      n_fail++;
      $display("FAIL overrun_pulse: pulses %0d chars %0d expected 1 and 1", ovr_cnt - o0, deliveries - d0);
    end
    check_char("overrun_keep");
    repeat (20) @(negedge clk);
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_dropped: valid_o got %b expected 0", valid_o);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    set_cfg(8, 0, 0, 0);
    rx_i = 1'b0;
    bit_wait();
    rx_i = 1'b1;
    repeat (3) bit_wait();
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || state_o !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_async: busy %b state %0d expected 0/IDLE", busy_o, state_o);
    end
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (32) @(negedge clk);
    d0 = deliveries;
    exp_q.push_back(model_char(8'h5A, 8, 0, 0, 0, 0, 1));
    send_frame(8'h5A, 8, 0, 0, 1, 0);
    n_checks++;
    if (deliveries - d0 != 1) begin
      n_fail++;
      $display("FAIL reset_mid_count: chars %0d expected 1", deliveries - d0);
    end
    check_char("reset_mid_5a");
  endtask

  task automatic test_random();
    logic [7:0] d;
    int nbits;
    bit pen, even, fp, pbit, stop;
    for (int n = 0; n < 24; n++) begin
      tick_div = (n >= 18) ? 2 : 1;
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      nbits = $urandom_range(5, 8);
      pen = 1'($urandom_range(0, 1));
      even = 1'($urandom_range(0, 1));
      fp = 1'($urandom_range(0, 1));
      pbit = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 5) != 0);
      set_cfg(nbits, pen, even, fp);
      exp_q.push_back(model_char(d, nbits, pen, even, fp, pbit, stop));
      send_frame(d, nbits, pen, pbit, stop, 1'b1);
      check_char($sformatf("random_%0d", n));
    end
    tick_div = 1;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected characters never delivered", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_engine.md
UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 Parameter OversampleRate, default 16: baud ticks per bit; even, range 4..32.
REQ-002 Parameter NrSyncStages, default 2: rx input synchroniser depth.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_ni  in  1  reset; asynchronous assert, active-low.
REQ-005 baud_tick_i  in  1  one-cycle pulse, OversampleRate per bit time.
REQ-006 rx_i  in  1  asynchronous serial line; idle high.
REQ-007 word_len_i  in  2  00:5, 01:6, 10:7, 11:8 data bits.
REQ-008 par_en_i, even_par_i, force_par_i  in  1 each  parity enable, even select, stick parity.
REQ-009 data_o  out  8  received character, LSB-aligned, unused upper bits 0.
REQ-010 valid_o  out  1  data_o and flags valid; held until ready_i.
REQ-011 ready_i  in  1  consumer accepts when valid_o && ready_i.
REQ-012 par_err_o, frame_err_o, break_o  out  1 each  flags qualified by valid_o.
REQ-013 overrun_o  out  1  one-cycle pulse; character dropped.
REQ-014 busy_o  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, START, DATA, PAR, STOP, RESYNC; the FSM and the tick counter advance only on baud_tick_i; the 3-sample window shifts on every baud_tick_i.
REQ-016 Sample value: majority vote of the last 3 synchronised rx samples taken on consecutive baud ticks.
REQ-017 IDLE->START: synchronised rx low on a tick; tick counter cleared.
REQ-018 START: after OversampleRate/2 ticks, sample; high -> IDLE (false start, no output); low -> DATA, word_len/parity config latched.
REQ-019 Config changes after START confirmation do not affect the current frame.
REQ-020 DATA: sample every OversampleRate ticks, LSB first; after the configured bit count -> PAR if parity enabled, else STOP.
REQ-021 PAR expected bit: force_par ? ~even_par : XOR(data) ^ ~even_par; mismatch sets par_err.
REQ-022 STOP: one sample; the second stop bit is never checked; a low sample sets frame_err.
REQ-023 Break: data all zero, parity bit (if enabled) zero and stop zero -> break and frame_err set, data_o 0x00.
REQ-024 After STOP: frame_err or break -> RESYNC; else -> IDLE.
REQ-025 RESYNC: stay until a sample is high, then IDLE; no new start is detected meanwhile.
REQ-026 Output load on the clock after the stop-sample tick: if valid_o is low or ready_i is high that cycle, load data and flags and set valid_o; else pulse overrun_o and drop the new character, keeping the old one.
REQ-027 Handshake clears valid_o unless a load occurs in the same cycle (load wins).
REQ-028 A break or framing frame is delivered as a character; it is subject to the same overrun rule.

Reset
REQ-029 Reset values: FSM IDLE; counters 0; sampler and synchroniser all ones (idle line); data_o 0x00; valid_o, flags, overrun_o, busy_o 0.
REQ-030 Reset mid-frame discards the partial character; no output is produced.

Structure
REQ-031 The FSM enum and the oversample range constants are defined in uart_pkg; the word-length decoding lives there as a function.
REQ-032 The synchroniser is the existing sync cell (NrSyncStages); the rest is one flat module, with no further sub-module.

Verification (OversampleRate=16, 1 tick/clk unless stated)
REQ-033 Send 8N1 0xA5 -> data_o=0xA5, valid_o high one clock after the stop-sample tick, flags 0.
REQ-034 Send 7E1 0x41 with parity bit 1 -> data_o=0x41, par_err_o=1; with parity bit 0 -> par_err_o=0.
REQ-035 Send a 4-tick low glitch -> no valid_o; FSM returns to IDLE; busy_o falls.
REQ-036 Hold rx low 2 frame times, then high -> one character: data_o=0x00, break_o=1, frame_err_o=1; next start only after the line is seen high.
REQ-037 Send 0x11 then 0x22 with ready_i=0 -> data_o stays 0x11, overrun_o pulses once; then ready_i=1 -> valid_o drops.
REQ-038 Assert rst_ni mid-DATA, release, send 0x5A -> only 0x5A is delivered.
